dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store port. It replaces the zero-latency combinational dmem with a valid/ready request channel and a valid/ready response channel.
- Latency is configurable, so the core's stall logic is exercised against a realistic slow memory.
- Sits between the core's data-access initiator and the backing storage array. Storage is a flat array of 64-bit words with byte write strobes.

Parameters:
- DEPTH, 1024: number of 64-bit words in storage; power of two.
- LATENCY, 2: wait cycles between request accept and response; legal range 0..15.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address (u32).
- req_we  in  1  1 = store, 0 = load.
- req_strobe  in  8  byte-lane write enables; bit i covers wdata[8i+7:8i].
- req_wdata  in  64  store data (word_t).
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  64  load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Reset values:
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
  - Storage contents are not cleared by reset.
- States are IDLE, WAIT and RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid && req_ready, latch addr, we, strobe and wdata. Load counter with LATENCY.
  - Next state is WAIT if LATENCY > 0, else RESP.
- WAIT:
  - req_ready = 0; the counter decrements each cycle.
  - When the counter reaches 1, move to RESP.
- Latency rule: a request accepted at edge T has resp_valid = 1 from edge T+1+LATENCY.
- Commit point: on entry to RESP.
  - Store: write each lane whose strobe bit is set; other lanes are unchanged. strobe = 0 is legal and leaves storage unchanged.
  - Load: resp_rdata = storage word read at the commit point. It reflects every earlier committed store.
- RESP:
  - req_ready = 0; resp_valid = 1.
  - resp_rdata and resp_err stay stable until resp_valid && resp_ready.
  - On that handshake, go to IDLE. resp_valid drops and req_ready rises at the next edge.
  - Minimum cycles per transaction = LATENCY + 2.
- Requests are never accepted while the responder is in WAIT or RESP. The initiator must hold req_valid and request fields stable until accepted.
- Address decode:
  - offset = req_addr - BASE_ADDR, 32-bit wrapping subtraction.
  - Word index = offset[log2(DEPTH)+2:3].
- Error cases:
  - offset[2:0] != 0 → resp_err = 1.
  - offset >= DEPTH*8 (including negative offsets that wrap to large values) → resp_err = 1.
  - An erroring access still goes through the full latency. A store is not written; resp_rdata = 0.
- Store responses return resp_rdata = 0, resp_err = 0 when legal.
- Reset mid-operation:
  - Reset during WAIT abandons the transaction; an uncommitted store is not written.
  - Reset during RESP drops the response; a store already committed stays written.
- resp_ready asserted while resp_valid = 0 is ignored.

Decomposition:
- Shared package (common) holds:
  - the mem_req_t struct (addr, we, strobe, wdata) and mem_resp_t struct (rdata, err);
  - the dmem_state_t enum (IDLE, WAIT, RESP);
  - the DMEM_BASE constant.
- One sub-module, dmem_array: DEPTH×64 storage with a registered byte-strobed write port and a combinational read port. dmem_responder owns the FSM, counter, decode and holding registers.

Test Plan:
- LATENCY = 2, store addr 32'h8000_0010, wdata 64'h1122_3344_5566_7788, strobe 8'hFF:
  - accepted at edge T, resp_valid first at T+3, resp_err = 0;
  - then a load of the same address returns 64'h1122_3344_5566_7788.
- Partial store, strobe 8'h0F, wdata 64'hAAAA_AAAA_BBBB_BBBB over the word above → load returns 64'h1122_3344_BBBB_BBBB.
- Load of 32'h8000_0004 → resp_err = 1, rdata = 0. Store to 32'h7FFF_FFF8 → resp_err = 1, and a load of word 0 is unchanged. Both errors take full latency.
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP →
  - resp_valid and rdata stay stable;
  - req_ready stays 0 with req_valid = 1 and a second request pending;
  - the second request is accepted exactly one cycle after the resp handshake.
- LATENCY = 0: request accepted at T, resp_valid at T+1. Back-to-back store then load to the same address with resp_ready tied 1 → each takes 2 cycles and the load returns the stored data.
- Reset one cycle after accepting a store with LATENCY = 4 →
  - resp_valid never asserts;
  - req_ready = 1 after reset;
  - a later load shows the old contents.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: request/response records,
// FSM state encoding and the default base address of the storage window.
package dmem_responder_pkg;

   localparam logic [31:0] DMEM_BASE = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  strobe;
      logic [63:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } mem_resp_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage with a byte-strobed registered write port and a
// combinational read port sharing one word address. Contents are never reset.
module dmem_array #(
   parameter int DEPTH = 1024,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    strobe,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata
);

   logic [63:0] mem [DEPTH];

   // Write only the byte lanes whose strobe bit is set.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (strobe[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels in front
// of dmem_array, with a programmable wait between accept and response.
//
//   state | meaning
//   IDLE  | ready for a request; req_ready = 1
//   WAIT  | request held, counting down the configured latency
//   RESP  | response presented and held until resp_ready
//
// The memory access (store commit or load read) happens on the edge that
// enters RESP, so a load sees every store committed before it.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter int          LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = DMEM_BASE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [7:0]  req_strobe,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH);

   dmem_state_t state, state_nxt;
   logic [3:0]  wait_cnt;
   mem_req_t    held;
   mem_req_t    cur;
   mem_resp_t   resp_q;
   logic        accept;
   logic        enter_resp;
   logic [31:0] offset;
   logic        addr_err;
   logic [AW-1:0] word_idx;
   logic [63:0] rd_word;
   logic        commit_we;

   assign accept = (state == IDLE) && req_valid;

   // With zero latency the commit happens on the accept edge, before the
   // holding register is loaded, so decode from the live request in IDLE.
   always_comb begin
      cur = held;
      if (state == IDLE) begin
         cur = '{addr: req_addr, we: req_we, strobe: req_strobe, wdata: req_wdata};
      end
   end

   // Window decode; the 33-bit compare keeps DEPTH*8 from overflowing and
   // negative offsets wrap to large values that land out of range.
   always_comb begin
      offset   = cur.addr - BASE_ADDR;
      addr_err = (offset[2:0] != 3'd0) || ({1'b0, offset} >= (33'(DEPTH) << 3));
      word_idx = offset[AW+2:3];
   end

   assign commit_we = enter_resp && cur.we && !addr_err && !reset;

   dmem_array #(
      .DEPTH(DEPTH)
   ) u_array (
      .clk    (clk),
      .we     (commit_we),
      .addr   (word_idx),
      .strobe (cur.strobe),
      .wdata  (cur.wdata),
      .rdata  (rd_word)
   );

   // Next-state logic; enter_resp marks the commit edge.
   always_comb begin
      state_nxt  = state;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd1) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, latency counter and response register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         resp_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            wait_cnt <= 4'(LATENCY);
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (enter_resp) begin
            resp_q.err   <= addr_err;
            resp_q.rdata <= (cur.we || addr_err) ? '0 : rd_word;
         end
      end
   end

   // Request holding register; its contents only matter after an accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         held <= cur;
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_rdata = resp_q.rdata;
   assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 0 and 4), a table of
// directed vectors, hand sequences for backpressure, back-to-back and reset
// abandonment, then random traffic against a word-array reference model.
module tb_dmem_responder;

   localparam int          ND   = 3;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset      [ND];
   logic        req_valid  [ND];
   logic        req_ready  [ND];
   logic [31:0] req_addr   [ND];
   logic        req_we     [ND];
   logic [7:0]  req_strobe [ND];
   logic [63:0] req_wdata  [ND];
   logic        resp_valid [ND];
   logic        resp_ready [ND];
   logic [63:0] resp_rdata [ND];
   logic        resp_err   [ND];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      dmem_responder #(
         .DEPTH     (1024),
         .LATENCY   (g == 0 ? 2 : (g == 1 ? 0 : 4)),
         .BASE_ADDR (BASE)
      ) dut (
         .clk        (clk),
         .reset      (reset[g]),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_addr   (req_addr[g]),
         .req_we     (req_we[g]),
         .req_strobe (req_strobe[g]),
         .req_wdata  (req_wdata[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_err   (resp_err[g])
      );
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 0 : 4);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: flat word array per instance, decoded from the byte
   // address with plain arithmetic. Words never fully written are unknown.
   logic [63:0] mref   [ND][1024];
   bit          mknown [ND][1024];

   task automatic model_apply(input int d, input logic [31:0] a, input logic we,
                              input logic [7:0] st, input logic [63:0] wd,
                              output logic er, output logic [63:0] rd, output bit rd_known);
      logic [31:0] off;
      int idx;
      off = a - BASE;
      er = (off % 8 != 0) || (off >= 32'd8192);
      rd = '0;
      rd_known = 1'b1;
      if (er) return;
      idx = int'(off / 8);
      if (we) begin
         for (int i = 0; i < 8; i++)
            if (st[i]) mref[d][idx][8*i +: 8] = wd[8*i +: 8];
         if (st == 8'hFF) mknown[d][idx] = 1'b1;
      end else begin
         rd = mref[d][idx];
         rd_known = mknown[d][idx];
      end
   endtask

   // One transaction. acc_c / hs_c are the cycle stamps of the accept edge
   // and of the response handshake edge; lat counts edges from accept to the
   // first edge at which resp_valid is high.
   task automatic txn(input int d, input logic [31:0] a, input logic we,
                      input logic [7:0] st, input logic [63:0] wd, input int hold,
                      input logic pend, input logic [31:0] pa, input logic rnd_rdy,
                      output logic [63:0] rd, output logic er, output int lat,
                      output int acc_c, output int hs_c);
      int k;
      logic [63:0] rd0;
      logic er0;
      req_valid[d]  = 1'b1;
      req_addr[d]   = a;
      req_we[d]     = we;
      req_strobe[d] = st;
      req_wdata[d]  = wd;
      k = 0;
      while (req_ready[d] !== 1'b1 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      acc_c = cyc;
      req_valid[d] = 1'b0;
      lat = 1;
      while (resp_valid[d] !== 1'b1 && lat < 40) begin
         resp_ready[d] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 40) chk("valid_timeout", 64'd0, 64'd1);
      rd0 = resp_rdata[d];
      er0 = resp_err[d];
      if (pend) begin
         req_valid[d]  = 1'b1;
         req_addr[d]   = pa;
         req_we[d]     = 1'b0;
         req_strobe[d] = 8'h00;
         req_wdata[d]  = '0;
      end
      for (int h = 0; h < hold; h++) begin
         resp_ready[d] = 1'b0;
         @(posedge clk); #1;
         chk("hold_valid", 64'(resp_valid[d]), 64'd1);
         chk("hold_rdata", resp_rdata[d], rd0);
         chk("hold_err", 64'(resp_err[d]), 64'(er0));
         if (pend) chk("hold_req_ready", 64'(req_ready[d]), 64'd0);
      end
      resp_ready[d] = 1'b1;
      @(posedge clk); #1;
      hs_c = cyc;
      resp_ready[d] = 1'b0;
      chk("post_hs_valid", 64'(resp_valid[d]), 64'd0);
      chk("post_hs_ready", 64'(req_ready[d]), 64'd1);
      rd = rd0;
      er = er0;
   endtask

   // Random-mode transaction checked against the reference model.
   task automatic rtxn(input int d, input logic [31:0] a, input logic we,
                       input logic [7:0] st, input logic [63:0] wd, input int hold);
      logic [63:0] rd, mrd;
      logic er, mer;
      bit mk;
      int lat, ac, hc;
      model_apply(d, a, we, st, wd, mer, mrd, mk);
      txn(d, a, we, st, wd, hold, 1'b0, '0, 1'b1, rd, er, lat, ac, hc);
      chk($sformatf("rnd_err d%0d a%h", d, a), 64'(er), 64'(mer));
      chk($sformatf("rnd_lat d%0d", d), 64'(lat), 64'(lat_of(d) + 1));
      if (mk) chk($sformatf("rnd_rdata d%0d a%h we%0d", d, a, we), rd, mrd);
   endtask

   typedef struct {
      int          d;
      logic [31:0] a;
      logic        we;
      logic [7:0]  st;
      logic [63:0] wd;
      logic        er;
      logic [63:0] rd;
      int          lat;
   } vec_t;

   vec_t vt [$];

   initial begin
      logic [63:0] rd, mrd, x;
      logic er, mer;
      bit mk, seen;
      int lat, a1, h1, a2, h2;

      vt.push_back('{0, 32'h8000_0010, 1'b1, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 3});
      vt.push_back('{0, 32'h8000_0010, 1'b0, 8'h00, 64'h0, 1'b0, 64'h1122_3344_5566_7788, 3});
      vt.push_back('{0, 32'h8000_0010, 1'b1, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0, 64'h0, 3});
      vt.push_back('{0, 32'h8000_0010, 1'b0, 8'h00, 64'h0, 1'b0, 64'h1122_3344_BBBB_BBBB, 3});
      vt.push_back('{0, 32'h8000_0004, 1'b0, 8'h00, 64'h0, 1'b1, 64'h0, 3});
      vt.push_back('{0, 32'h8000_0000, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 3});
      vt.push_back('{0, 32'h7FFF_FFF8, 1'b1, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 64'h0, 3});
      vt.push_back('{0, 32'h8000_0000, 1'b0, 8'h00, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF, 3});
      vt.push_back('{0, 32'h8000_0010, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 3});
      vt.push_back('{0, 32'h8000_0010, 1'b0, 8'h00, 64'h0, 1'b0, 64'h1122_3344_BBBB_BBBB, 3});
      vt.push_back('{0, 32'h8000_2000, 1'b0, 8'h00, 64'h0, 1'b1, 64'h0, 3});
      vt.push_back('{0, 32'h8000_1FF8, 1'b1, 8'hFF, 64'h55AA_55AA_0F0F_F0F0, 1'b0, 64'h0, 3});
      vt.push_back('{0, 32'h8000_1FF8, 1'b0, 8'h00, 64'h0, 1'b0, 64'h55AA_55AA_0F0F_F0F0, 3});
      vt.push_back('{0, 32'h8000_0013, 1'b1, 8'hFF, 64'h9999_9999_9999_9999, 1'b1, 64'h0, 3});
      vt.push_back('{0, 32'h8000_0010, 1'b0, 8'h00, 64'h0, 1'b0, 64'h1122_3344_BBBB_BBBB, 3});
      vt.push_back('{1, 32'h8000_0100, 1'b1, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 64'h0, 1});
      vt.push_back('{1, 32'h8000_0100, 1'b0, 8'h00, 64'h0, 1'b0, 64'h0F0E_0D0C_0B0A_0908, 1});
      vt.push_back('{2, 32'h8000_0040, 1'b1, 8'hFF, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0, 5});
      vt.push_back('{2, 32'h8000_0040, 1'b0, 8'h00, 64'h0, 1'b0, 64'h1234_5678_9ABC_DEF0, 5});

      for (int d = 0; d < ND; d++) begin
         reset[d]      = 1'b1;
         req_valid[d]  = 1'b0;
         req_addr[d]   = '0;
         req_we[d]     = 1'b0;
         req_strobe[d] = '0;
         req_wdata[d]  = '0;
         resp_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("rst_req_ready d%0d", d), 64'(req_ready[d]), 64'd1);
         chk($sformatf("rst_resp_valid d%0d", d), 64'(resp_valid[d]), 64'd0);
         chk($sformatf("rst_resp_rdata d%0d", d), resp_rdata[d], 64'd0);
         chk($sformatf("rst_resp_err d%0d", d), 64'(resp_err[d]), 64'd0);
         reset[d] = 1'b0;
      end

      // Directed table.
      foreach (vt[i]) begin
         txn(vt[i].d, vt[i].a, vt[i].we, vt[i].st, vt[i].wd, 0, 1'b0, '0, 1'b0,
             rd, er, lat, a1, h1);
         model_apply(vt[i].d, vt[i].a, vt[i].we, vt[i].st, vt[i].wd, mer, mrd, mk);
         chk($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].er));
         chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
      end

      // Backpressure: 5 stalled cycles with a second load pending.
      txn(0, 32'h8000_0010, 1'b0, 8'h00, '0, 5, 1'b1, 32'h8000_0000, 1'b0,
          rd, er, lat, a1, h1);
      chk("bp_rdata", rd, 64'h1122_3344_BBBB_BBBB);
      txn(0, 32'h8000_0000, 1'b0, 8'h00, '0, 0, 1'b0, '0, 1'b0, rd, er, lat, a2, h2);
      chk("bp_second_accept_cycle", 64'(a2), 64'(h1 + 1));
      chk("bp_second_rdata", rd, 64'h0123_4567_89AB_CDEF);

      // Zero latency back-to-back store then load.
      x = 64'hFEDC_BA98_7654_3210;
      txn(1, 32'h8000_0200, 1'b1, 8'hFF, x, 0, 1'b0, '0, 1'b0, rd, er, lat, a1, h1);
      model_apply(1, 32'h8000_0200, 1'b1, 8'hFF, x, mer, mrd, mk);
      txn(1, 32'h8000_0200, 1'b0, 8'h00, '0, 0, 1'b0, '0, 1'b0, rd, er, lat, a2, h2);
      chk("l0_store_to_load_cycles", 64'(a2 - a1), 64'd2);
      chk("l0_load_to_next_ready", 64'(h2 - a2), 64'd1);
      chk("l0_rdata", rd, x);
      chk("l0_lat", 64'(lat), 64'd1);

      // Reset one cycle after accepting a store on the latency-4 instance.
      req_valid[2]  = 1'b1;
      req_addr[2]   = 32'h8000_0040;
      req_we[2]     = 1'b1;
      req_strobe[2] = 8'hFF;
      req_wdata[2]  = 64'h0BAD_0BAD_0BAD_0BAD;
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      seen = resp_valid[2];
      @(posedge clk); #1;
      seen |= resp_valid[2];
      reset[2] = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         seen |= resp_valid[2];
      end
      reset[2] = 1'b0;
      chk("rst_mid_req_ready", 64'(req_ready[2]), 64'd1);
      chk("rst_mid_rdata", resp_rdata[2], 64'd0);
      repeat (8) begin
         @(posedge clk); #1;
         seen |= resp_valid[2];
      end
      chk("rst_mid_no_valid", 64'(seen), 64'd0);
      txn(2, 32'h8000_0040, 1'b0, 8'h00, '0, 0, 1'b0, '0, 1'b0, rd, er, lat, a1, h1);
      chk("rst_mid_old_contents", rd, 64'h1234_5678_9ABC_DEF0);

      // Random traffic: prefill a 20-word window, then mixed accesses.
      for (int d = 0; d < ND; d++)
         for (int w = 0; w < 20; w++)
            rtxn(d, BASE + 32'(w * 8), 1'b1, 8'hFF, {$urandom, $urandom}, 0);
      for (int n = 0; n < 90; n++) begin
         int d, sel;
         logic [31:0] a;
         d   = $urandom_range(0, ND - 1);
         sel = $urandom_range(0, 9);
         if (sel == 0)
            a = BASE + 32'($urandom_range(0, 19) * 8 + $urandom_range(1, 7));
         else if (sel == 1)
            a = $urandom_range(0, 1) ? BASE - 32'(8 * $urandom_range(1, 4))
                                     : BASE + 32'(8192 + 8 * $urandom_range(0, 3));
         else
            a = BASE + 32'($urandom_range(0, 19) * 8);
         rtxn(d, a, 1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom},
              $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
